// File: rtl/ysyx_24090013_rf_wb_arb.sv
// Register-file writeback arbiter: round-robin grant between EXU and LSU,
// one-cycle registered write port, and a busy-register scoreboard for RAW stalls.
module ysyx_24090013_rf_wb_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        exu_valid,
    input  logic [4:0]  exu_waddr,
    input  logic [31:0] exu_wdata,
    output logic        exu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_waddr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_ready,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        hazard,
    output logic [31:0] busy_mask
);

    // Handshake: a channel transfers when valid && ready at a posedge; the
    // requester holds valid/waddr/wdata until then. prio_q: 0 = EXU, 1 = LSU.
    logic        prio_q, prio_d;
    logic [31:0] busy_q, busy_d;
    logic        wen_q, wen_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        hs_exu, hs_lsu, hs_any;
    logic [4:0]  win_addr;
    logic [31:0] win_data;

    assign exu_ready = !rst && exu_valid && (!lsu_valid || !prio_q);
    assign lsu_ready = !rst && lsu_valid && (!exu_valid ||  prio_q);

    assign hs_exu   = exu_valid && exu_ready;
    assign hs_lsu   = lsu_valid && lsu_ready;
    assign hs_any   = hs_exu || hs_lsu;
    assign win_addr = hs_exu ? exu_waddr : lsu_waddr;
    assign win_data = hs_exu ? exu_wdata : lsu_wdata;

    always_comb begin
        prio_d  = prio_q;
        busy_d  = busy_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (hs_exu) begin
            prio_d = 1'b1;
        end else if (hs_lsu) begin
            prio_d = 1'b0;
        end
        if (hs_any) begin
            busy_d[win_addr] = 1'b0;
            wen_d            = (win_addr != 5'd0);
            waddr_d          = win_addr;
            wdata_d          = win_data;
        end
        // Set after clear so a same-cycle issue to the written register wins.
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q  <= 1'b0;
            busy_q  <= 32'd0;
            wen_q   <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            prio_q  <= prio_d;
            busy_q  <= busy_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign rf_wen    = wen_q;
    assign rf_waddr  = waddr_q;
    assign rf_wdata  = wdata_q;
    assign busy_mask = busy_q;
    // No writeback bypass: a register stays hazardous until its clear is registered.
    assign hazard    = busy_q[rs1_addr] | busy_q[rs2_addr];

endmodule

// File: tb/tb_ysyx_24090013_rf_wb_arb.sv
// Directed bench for the writeback arbiter: expected writes queued at grant
// time and compared one cycle later, scoreboard tracked by a small model.
module tb_ysyx_24090013_rf_wb_arb;

    logic        clk;
    logic        rst;
    logic        exu_valid;
    logic [4:0]  exu_waddr;
    logic [31:0] exu_wdata;
    logic        exu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_waddr;
    logic [31:0] lsu_wdata;
    logic        lsu_ready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        hazard;
    logic [31:0] busy_mask;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [36:0] exp_q[$];
    logic [31:0] m_busy;

    ysyx_24090013_rf_wb_arb dut (
        .clk         (clk),
        .rst         (rst),
        .exu_valid   (exu_valid),
        .exu_waddr   (exu_waddr),
        .exu_wdata   (exu_wdata),
        .exu_ready   (exu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_waddr   (lsu_waddr),
        .lsu_wdata   (lsu_wdata),
        .lsu_ready   (lsu_ready),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .hazard      (hazard),
        .busy_mask   (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_wb();
        logic [36:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rf_wen", {31'd0, rf_wen}, 32'd1);
            chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e[36:32]});
            chk("rf_wdata", rf_wdata, e[31:0]);
        end else begin
            chk("rf_wen_idle", {31'd0, rf_wen}, 32'd0);
        end
    endtask

    // g: expected grant this cycle (0 none, 1 EXU, 2 LSU).
    task automatic cycle(input int g);
        logic [4:0]  wa;
        logic [31:0] wd;
        #1;
        chk("exu_ready", {31'd0, exu_ready}, (g == 1) ? 32'd1 : 32'd0);
        chk("lsu_ready", {31'd0, lsu_ready}, (g == 2) ? 32'd1 : 32'd0);
        chk("hazard", {31'd0, hazard}, {31'd0, m_busy[rs1_addr] | m_busy[rs2_addr]});
        wa = (g == 1) ? exu_waddr : lsu_waddr;
        wd = (g == 1) ? exu_wdata : lsu_wdata;
        if (g != 0) begin
            m_busy[wa] = 1'b0;
            if (wa != 5'd0) exp_q.push_back({wa, wd});
        end
        if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_mask", busy_mask, m_busy);
        check_wb();
    endtask

    task automatic idle_inputs();
        exu_valid   = 1'b0;
        lsu_valid   = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        rs1_addr    = 5'd0;
        rs2_addr    = 5'd0;
    endtask

    initial begin
        int ch;
        rst = 1'b1;
        idle_inputs();
        exu_waddr = 5'd0; exu_wdata = 32'd0;
        lsu_waddr = 5'd0; lsu_wdata = 32'd0;
        m_busy = 32'd0;

        // Reset state, with both requesters asserting to prove ready is forced low.
        exu_valid = 1'b1; lsu_valid = 1'b1;
        #3;
        chk("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
        chk("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_exu_ready", {31'd0, exu_ready}, 32'd0);
        chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        chk("rst_hazard", {31'd0, hazard}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Contention: EXU, LSU, EXU, LSU.
        exu_waddr = 5'd1; exu_wdata = 32'h1111_0001;
        lsu_waddr = 5'd2; lsu_wdata = 32'h2222_0002;
        cycle(1);
        exu_waddr = 5'd3; exu_wdata = 32'h1111_0003;
        cycle(2);
        lsu_waddr = 5'd4; lsu_wdata = 32'h2222_0004;
        cycle(1);
        cycle(2);
        idle_inputs();
        cycle(0);

        // Single requester.
        exu_valid = 1'b1; exu_waddr = 5'd5; exu_wdata = 32'hDEAD_BEEF;
        cycle(1);
        idle_inputs();
        cycle(0);
        // Lone EXU is granted even though priority now points at LSU.
        exu_valid = 1'b1; exu_waddr = 5'd6; exu_wdata = 32'hCAFE_0006;
        cycle(1);
        idle_inputs();
        cycle(0);

        // Scoreboard set / hazard / clear by LSU writeback.
        issue_valid = 1'b1; issue_rd = 5'd7;
        cycle(0);
        chk("busy_r7", busy_mask, 32'h0000_0080);
        issue_valid = 1'b0; rs1_addr = 5'd7;
        lsu_valid = 1'b1; lsu_waddr = 5'd7; lsu_wdata = 32'h0000_1234;
        cycle(2);
        chk("busy_cleared", busy_mask, 32'd0);
        lsu_valid = 1'b0;
        cycle(0);

        // x0: no busy bit, handshake accepted, no register-file write.
        issue_valid = 1'b1; issue_rd = 5'd0;
        exu_valid = 1'b1; exu_waddr = 5'd0; exu_wdata = 32'h0000_AAAA;
        cycle(1);
        chk("x0_busy", busy_mask, 32'd0);
        idle_inputs();
        cycle(0);

        // Same-cycle issue and writeback to r3: issue wins.
        issue_valid = 1'b1; issue_rd = 5'd3;
        cycle(0);
        rs2_addr = 5'd3;
        exu_valid = 1'b1; exu_waddr = 5'd3; exu_wdata = 32'h3333_3333;
        cycle(1);
        chk("collide_busy", busy_mask, 32'h0000_0008);
        idle_inputs();
        rs2_addr = 5'd3;
        cycle(0);
        // Clearing r3, then clearing it again as a no-op.
        lsu_valid = 1'b1; lsu_waddr = 5'd3; lsu_wdata = 32'h3030_3030;
        cycle(2);
        cycle(2);
        idle_inputs();
        cycle(0);

        // Random single-requester traffic with random issues.
        for (int i = 0; i < 12; i++) begin
            ch = int'($urandom_range(0, 2));
            exu_valid   = (ch == 1);
            lsu_valid   = (ch == 2);
            exu_waddr   = 5'($urandom_range(0, 31));
            exu_wdata   = $urandom;
            lsu_waddr   = 5'($urandom_range(0, 31));
            lsu_wdata   = $urandom;
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 31));
            rs1_addr    = 5'($urandom_range(0, 31));
            rs2_addr    = 5'($urandom_range(0, 31));
            cycle(ch);
        end
        idle_inputs();
        cycle(0);

        // Fill the scoreboard; last step also writes r31 so rf_wen is high.
        for (int r = 1; r < 32; r++) begin
            issue_valid = 1'b1; issue_rd = 5'(r);
            if (r == 31) begin
                exu_valid = 1'b1; exu_waddr = 5'd31; exu_wdata = 32'h5A5A_5A5A;
                cycle(1);
            end else begin
                cycle(0);
            end
        end
        chk("full_busy", busy_mask, 32'hFFFF_FFFE);
        issue_valid = 1'b0;
        exu_valid = 1'b1; lsu_valid = 1'b1;
        #1;
        chk("pre_rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rf_wen", {31'd0, rf_wen}, 32'd0);
        chk("mid_rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("mid_rst_rf_wdata", rf_wdata, 32'd0);
        chk("mid_rst_busy", busy_mask, 32'd0);
        chk("mid_rst_exu_ready", {31'd0, exu_ready}, 32'd0);
        chk("mid_rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        exp_q.delete();
        m_busy = 32'd0;
        @(posedge clk);
        #1 rst = 1'b0;
        // Priority is back to EXU.
        exu_waddr = 5'd9;  exu_wdata = 32'h9999_9999;
        lsu_waddr = 5'd10; lsu_wdata = 32'hA0A0_A0A0;
        cycle(1);
        exu_valid = 1'b0;
        cycle(2);
        idle_inputs();
        cycle(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
